// File: rtl/grant_monitor.sv
// grant_monitor: watches the three arbitration acknowledges, tracks the
// current owner of the shared resource, captures the owner's data word on
// acquisition, counts grants per client and flags mutual-exclusion or
// over-long-hold violations.
module grant_monitor #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ackA,
    input  logic                             ackB,
    input  logic                             ackC,
    input  logic [WIDTH-1:0]                 dataA,
    input  logic [WIDTH-1:0]                 dataB,
    input  logic [WIDTH-1:0]                 dataC,
    output logic [1:0]                       owner,
    output logic                             busy,
    output logic [WIDTH-1:0]                 data_out,
    output logic                             data_valid,
    output logic [CNT_W-1:0]                 cntA,
    output logic [CNT_W-1:0]                 cntB,
    output logic [CNT_W-1:0]                 cntC,
    output logic [$clog2(MAX_HOLD+1)-1:0]    hold,
    output logic                             timeout,
    output logic                             conflict
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [1:0]    NONE     = 2'd3;

    typedef enum logic [1:0] {
        FREE,
        OWNED,
        ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        n_ack;
    logic [1:0]        sel;
    logic [WIDTH-1:0]  sel_data;
    logic              owner_ack;
    logic              acquire;
    logic              go_error;

    logic [1:0]        owner_nxt;
    logic              busy_nxt;
    logic [WIDTH-1:0]  data_out_nxt;
    logic              data_valid_nxt;
    logic [CNT_W-1:0]  cnt_a_nxt, cnt_b_nxt, cnt_c_nxt;
    logic [HW-1:0]     hold_nxt;
    logic              timeout_nxt;
    logic              conflict_nxt;

    // Decode the acknowledges: how many are high, which single one, and
    // whether the current owner still holds its ack.
    always_comb begin
        n_ack = {1'b0, ackA} + {1'b0, ackB} + {1'b0, ackC};
        if (ackA)      sel = 2'd0;
        else if (ackB) sel = 2'd1;
        else           sel = 2'd2;
        case (sel)
            2'd0:    sel_data = dataA;
            2'd1:    sel_data = dataB;
            default: sel_data = dataC;
        endcase
        case (owner)
            2'd0:    owner_ack = ackA;
            2'd1:    owner_ack = ackB;
            2'd2:    owner_ack = ackC;
            default: owner_ack = 1'b0;
        endcase
    end

    // Next-state and next-output logic; acquisition and error actions are
    // shared between FREE and OWNED so a handover behaves like a fresh grant.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        cnt_a_nxt      = cntA;
        cnt_b_nxt      = cntB;
        cnt_c_nxt      = cntC;
        hold_nxt       = hold;
        timeout_nxt    = timeout;
        conflict_nxt   = conflict;
        acquire        = 1'b0;
        go_error       = 1'b0;

        case (state)
            FREE: begin
                if (n_ack == 2'd1)      acquire  = 1'b1;
                else if (n_ack >= 2'd2) go_error = 1'b1;
            end
            OWNED: begin
                if (owner_ack) begin
                    if (n_ack == 2'd1) begin
                        hold_nxt = (hold == HOLD_MAX) ? hold : hold + 1'b1;
                        if (hold_nxt == HOLD_MAX) timeout_nxt = 1'b1;
                    end else begin
                        go_error = 1'b1;
                    end
                end else if (n_ack == 2'd0) begin
                    state_nxt = FREE;
                    owner_nxt = NONE;
                    hold_nxt  = '0;
                end else if (n_ack == 2'd1) begin
                    acquire = 1'b1;
                end else begin
                    go_error = 1'b1;
                end
            end
            default: go_error = 1'b1;
        endcase

        if (acquire) begin
            state_nxt      = OWNED;
            owner_nxt      = sel;
            data_out_nxt   = sel_data;
            data_valid_nxt = 1'b1;
            hold_nxt       = HW'(1);
            case (sel)
                2'd0:    if (cntA != '1) cnt_a_nxt = cntA + 1'b1;
                2'd1:    if (cntB != '1) cnt_b_nxt = cntB + 1'b1;
                default: if (cntC != '1) cnt_c_nxt = cntC + 1'b1;
            endcase
        end

        if (go_error) begin
            state_nxt    = ERROR;
            owner_nxt    = NONE;
            hold_nxt     = '0;
            conflict_nxt = 1'b1;
        end

        busy_nxt = (owner_nxt != NONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FREE;
            owner      <= NONE;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            cntA       <= '0;
            cntB       <= '0;
            cntC       <= '0;
            hold       <= '0;
            timeout    <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            busy       <= busy_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            cntA       <= cnt_a_nxt;
            cntB       <= cnt_b_nxt;
            cntC       <= cnt_c_nxt;
            hold       <= hold_nxt;
            timeout    <= timeout_nxt;
            conflict   <= conflict_nxt;
        end
    end

endmodule
